// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown driven by a synchronised 1 Hz tick.
// A start/pause/clear FSM gates the decrement; reaching 00:00 enters DONE
// and fires a single-cycle alarm.
module countdown_timer (
  input  logic       mclk,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       load,
  input  logic       clear,
  input  logic       start_stop,
  input  logic [3:0] pre_min_t,
  input  logic [3:0] pre_min_o,
  input  logic [2:0] pre_sec_t,
  input  logic [3:0] pre_sec_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e     state_q, state_d;
  logic       s1_q, s2_q, s3_q;
  logic [3:0] min_t_q, min_t_d;
  logic [3:0] min_o_q, min_o_d;
  logic [2:0] sec_t_q, sec_t_d;
  logic [3:0] sec_o_q, sec_o_d;
  logic       alarm_q, alarm_d;

  logic       tick;
  logic       is_zero;
  logic       is_one;

  // Clamp a 4-bit preset digit into the BCD range 0-9.
  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Synchroniser plus history flop; these run in every state so an edge
  // seen while paused is consumed and never replayed later.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sec_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick    = s2_q & ~s3_q;
  assign is_zero = (min_t_q == 4'd0) && (min_o_q == 4'd0) &&
                   (sec_t_q == 3'd0) && (sec_o_q == 4'd0);
  assign is_one  = (min_t_q == 4'd0) && (min_o_q == 4'd0) &&
                   (sec_t_q == 3'd0) && (sec_o_q == 4'd1);

  // State, digit and alarm registers.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      min_t_q <= 4'd0;
      min_o_q <= 4'd0;
      sec_t_q <= 3'd0;
      sec_o_q <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_t_q <= min_t_d;
      min_o_q <= min_o_d;
      sec_t_q <= sec_t_d;
      sec_o_q <= sec_o_d;
      alarm_q <= alarm_d;
    end
  end

  // Next state: clear > load > start_stop > tick. A load while running is
  // treated as absent, so lower-priority events still apply that cycle.
  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_o_d = min_o_q;
    sec_t_d = sec_t_q;
    sec_o_d = sec_o_q;
    alarm_d = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      min_t_d = 4'd0;
      min_o_d = 4'd0;
      sec_t_d = 3'd0;
      sec_o_d = 4'd0;
    end else if (load && (state_q != S_RUN)) begin
      state_d = S_IDLE;
      min_t_d = clamp9(pre_min_t);
      min_o_d = clamp9(pre_min_o);
      sec_t_d = (pre_sec_t > 3'd5) ? 3'd5 : pre_sec_t;
      sec_o_d = clamp9(pre_sec_o);
    end else if (start_stop && (state_q == S_RUN)) begin
      state_d = S_PAUSE;
    end else if (start_stop && ((state_q == S_IDLE) || (state_q == S_PAUSE))) begin
      if (!is_zero) begin
        state_d = S_RUN;
      end
    end else if (tick && (state_q == S_RUN)) begin
      if (is_zero || is_one) begin
        // Last second expires (00:00 in RUN cannot normally occur, but it
        // must never wrap to 99:59).
        sec_o_d = 4'd0;
        state_d = S_DONE;
        alarm_d = 1'b1;
      end else if (sec_o_q != 4'd0) begin
        sec_o_d = sec_o_q - 4'd1;
      end else begin
        sec_o_d = 4'd9;
        if (sec_t_q != 3'd0) begin
          sec_t_d = sec_t_q - 3'd1;
        end else begin
          sec_t_d = 3'd5;
          if (min_o_q != 4'd0) begin
            min_o_d = min_o_q - 4'd1;
          end else begin
            min_o_d = 4'd9;
            min_t_d = min_t_q - 4'd1;
          end
        end
      end
    end
  end

  assign min_t   = min_t_q;
  assign min_o   = min_o_q;
  assign sec_t   = sec_t_q;
  assign sec_o   = sec_o_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed steps plus a random phase, every cycle
// compared against a reference that tracks the count as total seconds.
module tb_countdown_timer;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_clk = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic       start_stop = 1'b0;
  logic [3:0] pre_min_t = 4'd0;
  logic [3:0] pre_min_o = 4'd0;
  logic [2:0] pre_sec_t = 3'd0;
  logic [3:0] pre_sec_o = 4'd0;
  logic [3:0] min_t, min_o, sec_o;
  logic [2:0] sec_t;
  logic       running, done, alarm;

  countdown_timer dut (
    .mclk(mclk), .reset(reset), .sec_clk(sec_clk), .load(load), .clear(clear),
    .start_stop(start_stop), .pre_min_t(pre_min_t), .pre_min_o(pre_min_o),
    .pre_sec_t(pre_sec_t), .pre_sec_o(pre_sec_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o), .running(running), .done(done), .alarm(alarm)
  );

  always #5 mclk = ~mclk;

  localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

  int total = 0;
  int bad = 0;
  int m_state;
  int m_secs;
  bit m_alarm;
  bit hq[$];       // sec_clk value seen at each past mclk edge
  int phase = 0;
  int half = 10;   // sec_clk half period in mclk cycles
  bit sec_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_state = IDLE;
    m_secs  = 0;
    m_alarm = 1'b0;
    hq.delete();
    repeat (3) hq.push_back(1'b0);
  endtask

  // A rising sec_clk sampled at edge k produces a decrement at edge k+2.
  function automatic bit tick_next();
    return hq[hq.size()-2] && !hq[hq.size()-3];
  endfunction

  task automatic model_edge();
    bit tk;
    if (reset) begin
      model_reset();
      return;
    end
    tk = tick_next();
    m_alarm = 1'b0;
    if (clear) begin
      m_state = IDLE;
      m_secs  = 0;
    end else if (load && m_state != RUN) begin
      m_state = IDLE;
      m_secs  = (clampv(pre_min_t, 9) * 10 + clampv(pre_min_o, 9)) * 60 +
                clampv(pre_sec_t, 5) * 10 + clampv(pre_sec_o, 9);
    end else if (start_stop && m_state == RUN) begin
      m_state = PAUSE;
    end else if (start_stop && (m_state == IDLE || m_state == PAUSE)) begin
      if (m_secs != 0) m_state = RUN;
    end else if (tk && m_state == RUN) begin
      if (m_secs > 0) m_secs--;
      if (m_secs == 0) begin
        m_state = DONE;
        m_alarm = 1'b1;
      end
    end
    hq.push_back(sec_clk);
    if (hq.size() > 4) void'(hq.pop_front());
  endtask

  task automatic check_all();
    int mins, secs;
    mins = m_secs / 60;
    secs = m_secs % 60;
    chk("min_t", min_t, mins / 10);
    chk("min_o", min_o, mins % 10);
    chk("sec_t", sec_t, secs / 10);
    chk("sec_o", sec_o, secs % 10);
    chk("running", running, m_state == RUN);
    chk("done", done, m_state == DONE);
    chk("alarm", alarm, m_alarm);
  endtask

  task automatic expect_time(input string tag, input int mm, input int ss);
    chk({tag, "_min"}, min_t * 10 + min_o, mm);
    chk({tag, "_sec"}, sec_t * 10 + sec_o, ss);
  endtask

  // One mclk cycle: advance sec_clk, apply the edge, check at the negedge,
  // then drop the single-cycle control pulses.
  task automatic cycle();
    if (sec_en) begin
      phase++;
      if (phase >= half) begin
        phase = 0;
        sec_clk = ~sec_clk;
      end
    end
    @(posedge mclk);
    model_edge();
    @(negedge mclk);
    check_all();
    load = 1'b0;
    clear = 1'b0;
    start_stop = 1'b0;
  endtask

  task automatic set_pre(input int mt, input int mo, input int st, input int so);
    pre_min_t = 4'(mt);
    pre_min_o = 4'(mo);
    pre_sec_t = 3'(st);
    pre_sec_o = 4'(so);
  endtask

  task automatic do_load(input int mt, input int mo, input int st, input int so);
    set_pre(mt, mo, st, so);
    load = 1'b1;
    cycle();
  endtask

  task automatic do_ss();
    start_stop = 1'b1;
    cycle();
  endtask

  task automatic wait_secs(input int n);
    for (int i = 0; i < n; i++) begin
      int s0, cnt;
      s0 = m_secs;
      cnt = 0;
      while (m_secs == s0 && cnt < 100) begin
        cycle();
        cnt++;
      end
      total++;
      assert (cnt < 100) else begin
        bad++;
        $error("FAIL wait_secs got=%0d exp=<100 cycles", cnt);
      end
    end
  endtask

  task automatic wait_tick();
    int cnt;
    cnt = 0;
    while (!tick_next() && cnt < 60) begin
      cycle();
      cnt++;
    end
    total++;
    assert (cnt < 60) else begin
      bad++;
      $error("FAIL wait_tick got=%0d exp=<60 cycles", cnt);
    end
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (m_state != DONE && cnt < 400) begin
      cycle();
      cnt++;
    end
    total++;
    assert (cnt < 400) else begin
      bad++;
      $error("FAIL wait_done got=%0d exp=<400 cycles", cnt);
    end
  endtask

  initial begin
    int alarm_cnt;
    model_reset();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    expect_time("reset", 0, 0);
    chk("reset_running", running, 0);
    $display("step reset: %0d%0d:%0d%0d", min_t, min_o, sec_t, sec_o);

    // Basic countdown from 00:03.
    do_load(0, 0, 0, 3);
    expect_time("load3", 0, 3);
    do_ss();
    sec_en = 1'b1;
    alarm_cnt = 0;
    while (m_state != DONE && alarm_cnt == 0 && total < 20000) begin
      cycle();
      if (alarm === 1'b1) alarm_cnt++;
    end
    wait_done();
    if (alarm === 1'b1 && alarm_cnt == 0) alarm_cnt++;
    repeat (3) begin
      cycle();
      if (alarm === 1'b1) alarm_cnt++;
    end
    chk("alarm_pulses", alarm_cnt, 1);
    chk("basic_done", done, 1);
    chk("basic_running", running, 0);
    expect_time("basic", 0, 0);
    $display("step basic: %0d%0d:%0d%0d done=%0d", min_t, min_o, sec_t, sec_o, done);

    // Borrow chain.
    do_load(1, 0, 0, 0);
    do_ss();
    wait_secs(1);
    expect_time("borrow10", 9, 59);
    do_ss();
    do_load(0, 1, 0, 0);
    do_ss();
    wait_secs(1);
    expect_time("borrow01", 0, 59);
    $display("step borrow: %0d%0d:%0d%0d", min_t, min_o, sec_t, sec_o);

    // Pause and resume.
    do_ss();
    do_load(0, 0, 1, 0);
    do_ss();
    wait_secs(2);
    expect_time("run2", 0, 8);
    do_ss();
    repeat (3 * 2 * half) cycle();
    expect_time("paused", 0, 8);
    do_ss();
    wait_secs(1);
    expect_time("resumed", 0, 7);
    $display("step pause: %0d%0d:%0d%0d", min_t, min_o, sec_t, sec_o);

    // start_stop colliding with a tick, in RUN then in PAUSE.
    wait_tick();
    do_ss();
    expect_time("coll_run", 0, 7);
    chk("coll_run_running", running, 0);
    wait_tick();
    do_ss();
    expect_time("coll_pause", 0, 7);
    chk("coll_pause_running", running, 1);
    // Load while running is ignored.
    while (tick_next()) cycle();
    do_load(3, 3, 3, 3);
    expect_time("load_in_run", 0, 7);
    chk("load_in_run_running", running, 1);
    clear = 1'b1;
    cycle();
    expect_time("clear_in_run", 0, 0);
    chk("clear_running", running, 0);
    $display("step collisions: %0d%0d:%0d%0d", min_t, min_o, sec_t, sec_o);

    // Clamp and zero start.
    do_load(0, 0, 7, 12);
    expect_time("clamp", 0, 59);
    do_load(12, 15, 2, 3);
    expect_time("clamp_min", 99, 23);
    do_load(0, 0, 0, 0);
    do_ss();
    chk("zero_start_running", running, 0);
    expect_time("zero_start", 0, 0);
    $display("step clamp: %0d%0d:%0d%0d", min_t, min_o, sec_t, sec_o);

    // Asynchronous reset mid-run.
    do_load(0, 5, 3, 0);
    do_ss();
    expect_time("pre_reset", 5, 30);
    #2 reset = 1'b1;
    #1;
    chk("areset_min_t", min_t, 0);
    chk("areset_min_o", min_o, 0);
    chk("areset_sec_t", sec_t, 0);
    chk("areset_sec_o", sec_o, 0);
    chk("areset_running", running, 0);
    chk("areset_done", done, 0);
    chk("areset_alarm", alarm, 0);
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (4 * half) cycle();
    expect_time("post_reset", 0, 0);
    chk("post_reset_running", running, 0);
    do_load(0, 0, 0, 2);
    do_ss();
    wait_done();
    chk("post_reset_done", done, 1);
    $display("step areset: %0d%0d:%0d%0d done=%0d", min_t, min_o, sec_t, sec_o, done);

    // Random control traffic with varying sec_clk rates.
    for (int i = 0; i < 800; i++) begin
      int r;
      if (i % 100 == 0) half = $urandom_range(2, 12);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        clear = 1'b1;
      end else if (r < 7 && m_state != RUN) begin
        set_pre(($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0,
                $urandom_range(0, 7) % 3 == 0 ? $urandom_range(0, 7) : 0,
                $urandom_range(0, 15));
        load = 1'b1;
      end else if (r < 13) begin
        start_stop = 1'b1;
      end
      cycle();
    end
    $display("step random: %0d%0d:%0d%0d", min_t, min_o, sec_t, sec_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD minutes:seconds countdown timer that consumes the 1 Hz square wave produced by the one-second clock divider and drives the four-digit display path. It synchronises the incoming slow clock into the `mclk` domain, turns each rising edge into a one-cycle tick, and decrements a preset MM:SS value under a start/pause/clear control FSM. When the count reaches 00:00 it raises a done level and a one-cycle alarm pulse.

## Interface
- No parameters. Digit ranges are fixed: minutes 00–99, seconds 00–59.
- `mclk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sec_clk`  in  1  1 Hz square wave from the one-second divider. Asynchronous to the FSM; each rising edge is one second.
- `load`  in  1  one-`mclk` pulse: copy preset digits into the counter.
- `clear`  in  1  one-`mclk` pulse: zero the counter and return to IDLE.
- `start_stop`  in  1  one-`mclk` pulse: toggle between RUN and PAUSE.
- `pre_min_t`  in  4  preset minutes tens, BCD.
- `pre_min_o`  in  4  preset minutes ones, BCD.
- `pre_sec_t`  in  3  preset seconds tens, BCD 0–5.
- `pre_sec_o`  in  4  preset seconds ones, BCD.
- `min_t`, `min_o`, `sec_o`  out  4  current digits, BCD.
- `sec_t`  out  3  current seconds tens digit.
- `running`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `alarm`  out  1  one-`mclk` pulse on entry to DONE.

## Operation
- **Tick generation**
  - `sec_clk` passes through a 2-flop synchroniser (s1, s2), then a history flop s3.
  - `tick = s2 & ~s3`: exactly one `mclk` cycle per `sec_clk` rising edge.
- **FSM states:** IDLE, RUN, PAUSE, DONE.
- **Priority per cycle:** `reset` > `clear` > `load` > `start_stop` > `tick`.
- **`clear`:** from any state → IDLE, all digits 0.
- **`load`:**
  - In IDLE, PAUSE or DONE: digits ← preset, state → IDLE.
  - In RUN: ignored.
  - Clamp on load: any 4-bit digit > 9 loads as 9; `pre_sec_t` > 5 loads as 5.
- **`start_stop`:**
  - IDLE or PAUSE with counter ≠ 00:00 → RUN.
  - IDLE or PAUSE with counter = 00:00 → ignored.
  - RUN → PAUSE.
  - DONE → ignored.
- **`tick` in RUN, no higher-priority event:** decrement by one second.
  - `sec_o` 0→9 borrows from `sec_t`.
  - `sec_t` 0→5 borrows from `min_o`.
  - `min_o` 0→9 borrows from `min_t`.
  - If the decremented value equals 00:00: state → DONE and `alarm` = 1 for the following cycle.
- **`tick` outside RUN:** no effect. Synchroniser flops keep running in all states, so a stale edge is never replayed after RUN resumes.
- **Simultaneous events:**
  - `start_stop` + `tick` in RUN → PAUSE, no decrement.
  - `start_stop` + `tick` in PAUSE → RUN, no decrement.
  - `clear` + `tick` → cleared.
- Digits never leave the BCD ranges above; no wrap from 00:00 to 99:59.

## Timing
- **Reset values:**
  - State IDLE; s1/s2/s3 = 0.
  - All digits 0; `running`, `done`, `alarm` = 0.
  - Because s3 = 0, a `sec_clk` already high at reset release produces one tick, which is harmless in IDLE.
- **Tick latency:** `sec_clk` rises before `mclk` edge N → s1 = 1 after N, s2 = 1 after N+1, tick high during cycle N+1→N+2, digits update on edge N+2.
- **Control latency:** `load`, `clear` and `start_stop` sampled on edge K take effect in outputs after edge K. `running` and `done` are registered state decodes.
- **Alarm:** `alarm` is registered, high exactly one cycle, coincident with the first cycle of `done`.
- **Reset mid-operation:** asynchronous; all outputs reach reset values immediately, regardless of state or pending tick.

## Test plan
- **Basic countdown:** reset; load 00:03; pulse `start_stop`; 3 `sec_clk` rising edges (period 20 `mclk`).
  - Digits go 00:02, 00:01, 00:00, each update 2 edges after the synchronised edge.
  - On reaching 00:00: `done` = 1, `alarm` exactly 1 cycle, `running` = 0.
- **Borrow chain:** load 10:00; run; 1 tick → 09:59.
  - Load 01:00; run; 1 tick → 00:59.
- **Pause/resume:** load 00:10; run 2 ticks (00:08); `start_stop` → PAUSE.
  - 3 ticks with no change; `start_stop` → resumes; next tick → 00:07.
- **Priority and collisions:**
  - `start_stop` in the same cycle as a tick in RUN → PAUSE, value unchanged.
  - `load` during RUN is ignored.
  - `clear` during RUN → IDLE, 00:00.
- **Clamp and zero-start:**
  - Load `pre_sec_t` = 7, `pre_sec_o` = 12, `pre_min_t` = 0, `pre_min_o` = 0 → displays 00:59.
  - Load 00:00 then `start_stop` → stays IDLE, `running` = 0.
- **Async reset mid-run:** assert `reset` between `mclk` edges while at 05:30 RUN.
  - All outputs are 0 immediately.
  - After release, ticks do not decrement until load + start.
